// File: rtl/mem_rr_arbiter_ctrl.sv
// mem_rr_arbiter_ctrl: two-requester round-robin controller for a single-port synchronous memory.
// Optional MEM_ARB_FIXED_PRIO_EN: requester 0 always wins a tie instead of alternating.
`default_nettype none

module mem_rr_arbiter_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                busy,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic                last_gnt;
  logic                owner;
  logic                gnt;
  logic                hs;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rdata_q;

  // Tie-break favours the requester that did not complete most recently.
  always_comb begin
    gnt = 1'b0;
    case (req_valid)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
      2'b11:   gnt = 1'b0;
`else
      2'b11:   gnt = ~last_gnt;
`endif
      default: gnt = 1'b0;
    endcase
  end

  always_comb begin
    req_ready    = 2'b00;
    req_ready[0] = (state == IDLE) && req_valid[0] && !gnt;
    req_ready[1] = (state == IDLE) && req_valid[1] && gnt;
    hs           = |(req_valid & req_ready);
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    rsp_valid = 2'b00;
    case (state)
      IDLE: begin
        if (hs) state_nxt = req_we[gnt] ? WRITE : READ;
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        state_nxt = DONE;
      end
      READ: begin
        mem_en = (cnt == '0);
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        rsp_valid[owner] = 1'b1;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      owner    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (hs) begin
            owner   <= gnt;
            we_q    <= req_we[gnt];
            addr_q  <= gnt ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
            wdata_q <= gnt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
            cnt     <= '0;
          end
        end
        READ: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) rdata_q <= mem_rdata;
        end
        DONE: last_gnt <= owner;
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_rr_arbiter_ctrl.sv
// Directed self-checking bench for mem_rr_arbiter_ctrl with a RD_LAT-cycle memory model.
`default_nettype none

module tb_mem_rr_arbiter_ctrl;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_we = '0;
  logic [15:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
  logic        busy, mem_en, mem_we;
  logic [7:0]  mem_addr;

  int n_checks = 0;
  int n_fail   = 0;

  mem_rr_arbiter_ctrl #(.ADDR_W(8), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: writes on strobe, reads return data RD_LAT cycles after the strobe.
  logic [31:0] mem [256];
  logic [31:0] pipe [RD_LAT];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem_init <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    pipe[0] <= mem[mem_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [31:0] d);
    req_we[i]            = we;
    req_addr[i*8 +: 8]   = a;
    req_wdata[i*32 +: 32] = d;
    req_valid[i]         = 1'b1;
  endtask

  initial begin
    int n, cyc, last, n0, n1, exp_g, pend, g, rsp_seen;

    // Reset state
    tick(); tick();
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    tick();
    rst = 1'b0;
    tick();
    #1;
    check_eq("idle_no_req_ready", req_ready, 2'b00);

    // T2: write from requester 0
    set_req(0, 1'b1, 8'h10, 32'hDEADBEEF);
    #1;
    check_eq("t2_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    #1;
    check_eq("t2_mem_en", mem_en, 1);
    check_eq("t2_mem_we", mem_we, 1);
    check_eq("t2_mem_addr", mem_addr, 8'h10);
    check_eq("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check_eq("t2_no_rsp_yet", rsp_valid, 2'b00);
    tick(); #1;
    check_eq("t2_rsp_valid", rsp_valid, 2'b01);
    check_eq("t2_mem_en_off", mem_en, 0);
    check_eq("t2_rdata_untouched", rsp_rdata, 0);
    tick(); #1;
    check_eq("t2_idle", busy, 0);
    check_eq("t2_rsp_pulse", rsp_valid, 2'b00);

    // T3: read from requester 1, RD_LAT+2 cycles to response
    set_req(1, 1'b0, 8'h10, 32'h0);
    #1;
    check_eq("t3_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    #1;
    check_eq("t3_mem_en", mem_en, 1);
    check_eq("t3_mem_we", mem_we, 0);
    n = 1;
    while (rsp_valid == 2'b00 && n < 20) begin
      tick(); #1;
      n++;
      if (n == 2) check_eq("t3_mem_en_once", mem_en, 0);
    end
    check_eq("t3_latency", n, 4);
    check_eq("t3_rsp_valid", rsp_valid, 2'b10);
    check_eq("t3_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    tick();

    // T6: requester 0 pulses valid while busy and is never served
    set_req(1, 1'b1, 8'h20, 32'h00001111);
    tick();
    req_valid = 2'b00;
    set_req(0, 1'b1, 8'h30, 32'h00003333);
    #1;
    check_eq("t6_busy_ready", req_ready, 2'b00);
    tick();
    req_valid = 2'b00;
    #1;
    check_eq("t6_rsp_owner", rsp_valid, 2'b10);
    rsp_seen = 0;
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      if (rsp_valid != 2'b00 || busy) rsp_seen++;
    end
    check_eq("t6_no_grant", rsp_seen, 0);
    check_eq("t6_mem30", mem[8'h30], 32'h0);
    check_eq("t6_mem20", mem[8'h20], 32'h00001111);
    check_eq("t6_rdata_kept", rsp_rdata, 32'hDEADBEEF);

    // T4 / T5: both requesters hold valid for 4 writes each
    cyc = 0; last = -1; n0 = 0; n1 = 0; exp_g = 0; pend = 0;
    set_req(0, 1'b1, 8'h40, 32'h0A000000);
    set_req(1, 1'b1, 8'h80, 32'h0B000000);
    while ((n0 < 4 || n1 < 4 || busy) && cyc < 80) begin
      #1;
      g = -1;
      if (rsp_valid != 2'b00) check_eq("t4_rsp_owner", rsp_valid, (pend == 1) ? 2'b10 : 2'b01);
      if (req_ready != 2'b00) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_g = (n0 < 4) ? 0 : 1;
`endif
        check_eq("t4_grant", req_ready, (exp_g == 1) ? 2'b10 : 2'b01);
        if (last >= 0) check_eq("t4_gap", cyc - last, 3);
        g = req_ready[1] ? 1 : 0;
        pend = g;
        last = cyc;
`ifndef MEM_ARB_FIXED_PRIO_EN
        exp_g = 1 - exp_g;
`endif
        if (g == 0) n0++; else n1++;
      end
      tick();
      cyc++;
      if (g == 0) begin
        if (n0 == 4) req_valid[0] = 1'b0;
        else set_req(0, 1'b1, 8'(8'h40 + n0), 32'h0A000000 + n0);
      end else if (g == 1) begin
        if (n1 == 4) req_valid[1] = 1'b0;
        else set_req(1, 1'b1, 8'(8'h80 + n1), 32'h0B000000 + n1);
      end
    end
    check_eq("t4_timeout", (cyc < 80) ? 1 : 0, 1);
    check_eq("t4_count", n0 + n1, 8);
    for (int k = 0; k < 4; k++) begin
      check_eq("t4_mem0", mem[8'h40 + k], 32'h0A000000 + k);
      check_eq("t4_mem1", mem[8'h80 + k], 32'h0B000000 + k);
    end

    // T1: reset in the middle of a read
    tick();
    set_req(0, 1'b0, 8'h40, 32'h0);
    tick();
    req_valid = 2'b00;
    tick();
    rst = 1'b1;
    #1;
    check_eq("t1_busy", busy, 0);
    check_eq("t1_rsp_valid", rsp_valid, 2'b00);
    check_eq("t1_mem_en", mem_en, 0);
    check_eq("t1_rdata_cleared", rsp_rdata, 0);
    tick();
    rst = 1'b0;
    rsp_seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick(); #1;
      if (rsp_valid != 2'b00) rsp_seen++;
    end
    check_eq("t1_no_rsp", rsp_seen, 0);
    req_valid = 2'b11;
    #1;
    check_eq("t1_first_winner", req_ready, 2'b01);
    req_valid = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
